matvec_mac_engine: RTL
======================

// Module: matvec_mac_engine
// PURPOSE
//  Parametrised matrix-vector MAC engine: fetches vector B and N rows of matrix A from the
//  Avalon-MM read port of mem_wrapper, then computes C[i] = sum_j A[i][j]*B[j] for i=0..N-1.
//  Results stream out over a valid/ready port, one per row.
//  Adds selectable wrap/saturate accumulation and output backpressure.
//  Sits between mem_wrapper and the HEX/LED display logic at the top level.
// PARAMETERS
//  N         8    matrix dimension (rows of A = elements of B), 2..16
//  DW        8    element width, unsigned
//  ACCW      24   accumulator/result width; must be >= 2*DW
//  AW        32   memory word-address width
//  BASE_ADDR 0    word address of B; A row i is at BASE_ADDR+1+i
//  SATURATE  0    0: accumulate modulo 2^ACCW; 1: clamp at 2^ACCW-1
// PORTS
//  CLOCK_50          in   1      clock, all logic on posedge
//  rst_n             in   1      asynchronous, active-low reset
//  start             in   1      one-cycle request to begin; ignored unless idle
//  busy              out  1      high from accepted start until done pulse
//  done              out  1      one-cycle pulse after last result accepted
//  mem_address       out  AW     word address to mem_wrapper
//  mem_read          out  1      read request
//  mem_readdata      in   N*DW   row word; element 0 in MSBs [N*DW-1 -: DW]
//  mem_readdatavalid in   1      readdata valid this cycle
//  mem_waitrequest   in   1      memory stall; request must be held
//  result_valid      out  1      result_data/result_index valid
//  result_ready      in   1      consumer accepts when valid & ready
//  result_data       out  ACCW   C[result_index]
//  result_index      out  $clog2(N)  row number of current result
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, accumulator, B buffer and row counter cleared.
//  Reset mid-operation aborts immediately; no done pulse; next start runs cleanly.
//  FSM states:
//   IDLE   -> RD_B on start (busy=1 next cycle).
//   RD_B   mem_read=1, addr=BASE_ADDR; hold both while waitrequest; -> WT_B when waitrequest=0.
//   WT_B   wait readdatavalid; latch B into N-entry register; -> RD_A.
//   RD_A   mem_read=1, addr=BASE_ADDR+1+row; same hold rule; -> WT_A.
//   WT_A   wait readdatavalid; latch row; clear accumulator; -> MAC.
//   MAC    exactly N cycles, column j=0..N-1, one product A[row][j]*B[j] per cycle; -> EMIT.
//   EMIT   result_valid=1, data/index held stable until result_ready.
//          On handshake: row<N-1 -> row++, RD_A; else -> DONE.
//   DONE   done=1 for one cycle, busy=0; -> IDLE.
//  Memory rules:
//   - mem_read asserted only in RD_B/RD_A.
//   - Exactly one outstanding read.
//   - readdatavalid outside WT_B/WT_A is ignored.
//  Arithmetic: product 2*DW bits, zero-extended to ACCW.
//   - SATURATE=0: sum wraps modulo 2^ACCW.
//   - SATURATE=1: carry-out or prior clamp forces all-ones, sticky for the row.
//  Latency: zero-wait memory with readdatavalid 1 cycle after accept gives N+3 cycles
//   per row from RD_A to first EMIT cycle.
//  start while busy: no effect. result_ready while !result_valid: no effect.
//  N must divide cleanly into the readdata word: element j = mem_readdata[(N-j)*DW-1 -: DW].
// TESTING
//  1 A=identity, B={1..8}, N=8, ready=1 -> results 1,2,...,8 at index 0..7, then one done pulse.
//  2 All elements 255, ACCW=16, SATURATE=0 -> every C=61448 (520200 mod 65536);
//    SATURATE=1 -> every C=65535.
//  3 waitrequest high 3 cycles on RD_A row 2 -> mem_read/mem_address=BASE+3 stable all
//    3 cycles, single read issued, C[2] correct.
//  4 result_ready low 5 cycles at row 4 -> result_valid high and data/index stable
//    for 5 cycles, no row skipped.
//  5 rst_n low during MAC of row 3 -> all outputs 0 async; new start yields full correct
//    result set 0..7.
//  6 start pulsed while busy, spurious readdatavalid in MAC -> ignored, results unchanged.

Source files
------------

// File: rtl/matvec_mac_engine.sv
// Matrix-vector MAC engine: reads vector B and N rows of A over Avalon-MM, then streams
// C[i] = sum_j A[i][j]*B[j] one row at a time over a valid/ready port.
//
//  state  | meaning
//  IDLE   | waiting for start
//  RD_B   | read request for vector B (held through waitrequest)
//  WT_B   | waiting for B readdata
//  RD_A   | read request for row `row_q` of A
//  WT_A   | waiting for row readdata, accumulator cleared on arrival
//  MAC    | one product per cycle, column col_q = 0..N-1
//  EMIT   | result presented until accepted
//  DONE   | one-cycle done pulse
module matvec_mac_engine #(
  parameter int          N         = 8,
  parameter int          DW        = 8,
  parameter int          ACCW      = 24,
  parameter int          AW        = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          SATURATE  = 0
) (
  input  logic                 CLOCK_50,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        mem_address,
  output logic                 mem_read,
  input  logic [N*DW-1:0]      mem_readdata,
  input  logic                 mem_readdatavalid,
  input  logic                 mem_waitrequest,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ACCW-1:0]      result_data,
  output logic [$clog2(N)-1:0] result_index
);

  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_B, S_WT_B, S_RD_A, S_WT_A, S_MAC, S_EMIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   row_q, row_d;
  logic [IW-1:0]   col_q, col_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            sat_q, sat_d;
  logic [DW-1:0]   b_q [N];
  logic [DW-1:0]   b_d [N];
  logic [DW-1:0]   a_q [N];
  logic [DW-1:0]   a_d [N];

  logic [2*DW-1:0] prod;
  logic [ACCW:0]   sum;

  assign prod = a_q[col_q] * b_q[col_q];
  assign sum  = {1'b0, acc_q} + (ACCW+1)'(prod);

  assign result_data  = acc_q;
  assign result_index = row_q;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    acc_d        = acc_q;
    sat_d        = sat_q;
    b_d          = b_q;
    a_d          = a_q;
    busy         = 1'b1;
    done         = 1'b0;
    mem_read     = 1'b0;
    mem_address  = '0;
    result_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          row_d   = '0;
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        mem_read    = 1'b1;
        mem_address = AW'(BASE_ADDR);
        if (!mem_waitrequest) state_d = S_WT_B;
      end
      S_WT_B: begin
        if (mem_readdatavalid) begin
          for (int j = 0; j < N; j++) b_d[j] = mem_readdata[(N-j)*DW-1 -: DW];
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        mem_read    = 1'b1;
        mem_address = AW'(BASE_ADDR) + AW'(row_q) + AW'(1);
        if (!mem_waitrequest) state_d = S_WT_A;
      end
      S_WT_A: begin
        if (mem_readdatavalid) begin
          for (int j = 0; j < N; j++) a_d[j] = mem_readdata[(N-j)*DW-1 -: DW];
          acc_d   = '0;
          sat_d   = 1'b0;
          col_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        // Once a row has clamped it stays clamped, even if later products are zero.
        if ((SATURATE != 0) && (sat_q || sum[ACCW])) begin
          acc_d = '1;
          sat_d = 1'b1;
        end else begin
          acc_d = sum[ACCW-1:0];
        end
        if (col_q == IW'(N-1)) state_d = S_EMIT;
        else                   col_d   = col_q + IW'(1);
      end
      S_EMIT: begin
        result_valid = 1'b1;
        if (result_ready) begin
          if (row_q == IW'(N-1)) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + IW'(1);
            state_d = S_RD_A;
          end
        end
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      for (int j = 0; j < N; j++) begin
        b_q[j] <= '0;
        a_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      b_q     <= b_d;
      a_q     <= a_d;
    end
  end

endmodule
